// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage defines (word width, opcodes, state codes) and the package that exposes them as typed constants.
`default_nettype none

`ifndef FETCH_DEFINES_SVH
`define FETCH_DEFINES_SVH
`define WIDTH        32
`define OPCODE_MSB   31
`define OPCODE_LSB   27
`define MOV          5'h01
`define ADD          5'h02
`define MPY          5'h03
`define CMP          5'h04
`define BR           5'h05
`define HALT         5'h1F
`define FS_RUN       2'd0
`define FS_HALT_WAIT 2'd1
`define FS_HALTED    2'd2
`define FS_FAULT     2'd3
`endif

package fetch_unit_pkg;

  localparam int OPCODE_MSB = `OPCODE_MSB;
  localparam int OPCODE_LSB = `OPCODE_LSB;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_W-1:0] OP_MOV  = `MOV;
  localparam logic [OPCODE_W-1:0] OP_ADD  = `ADD;
  localparam logic [OPCODE_W-1:0] OP_MPY  = `MPY;
  localparam logic [OPCODE_W-1:0] OP_CMP  = `CMP;
  localparam logic [OPCODE_W-1:0] OP_BR   = `BR;
  localparam logic [OPCODE_W-1:0] OP_HALT = `HALT;

  typedef enum logic [1:0] {
    FS_RUN       = `FS_RUN,
    FS_HALT_WAIT = `FS_HALT_WAIT,
    FS_HALTED    = `FS_HALTED,
    FS_FAULT     = `FS_FAULT
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: drives the imem PC, buffers one fetched word, and
// hands it to decode over valid/ready; handles redirects, HALT and out-of-range faults.
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int          IMEM_DEPTH = 16,
  parameter int          WIDTH      = `WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_pc,
  input  logic [WIDTH-1:0] imem_inst,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst_data,
  output logic [31:0]      inst_pc,
  output logic             halted,
  output logic             fetch_fault
);

  fetch_state_e state;
  logic [31:0]  fetch_pc;

  logic transfer;
  logic slot_free;
  logic pc_out_of_range;
  logic is_halt;

  assign imem_pc         = fetch_pc;
  assign transfer        = inst_valid && inst_ready;
  assign slot_free       = !inst_valid || transfer;
  assign pc_out_of_range = fetch_pc >= 32'(IMEM_DEPTH);
  assign is_halt         = imem_inst[OPCODE_MSB:OPCODE_LSB] == OP_HALT;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FS_RUN;
      fetch_pc    <= RESET_PC;
      inst_valid  <= 1'b0;
      inst_data   <= '0;
      inst_pc     <= '0;
      halted      <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        FS_RUN: begin
          if (redirect_valid) begin
            // A word handed over this same cycle still counts as delivered.
            inst_valid <= 1'b0;
            fetch_pc   <= redirect_pc;
          end else if (slot_free && pc_out_of_range) begin
            inst_valid  <= 1'b0;
            state       <= FS_FAULT;
            fetch_fault <= 1'b1;
          end else if (slot_free) begin
            inst_valid <= 1'b1;
            inst_data  <= imem_inst;
            inst_pc    <= fetch_pc;
            if (is_halt) begin
              // fetch_pc stays parked on the HALT so imem_pc reports it.
              state <= FS_HALT_WAIT;
            end else begin
              fetch_pc <= fetch_pc + 32'd1;
            end
          end
        end

        FS_HALT_WAIT: begin
          if (redirect_valid) begin
            inst_valid <= 1'b0;
            fetch_pc   <= redirect_pc;
            state      <= FS_RUN;
          end else if (transfer) begin
            inst_valid <= 1'b0;
            halted     <= 1'b1;
            state      <= FS_HALTED;
          end
        end

        FS_HALTED: begin
          inst_valid <= 1'b0;
        end

        FS_FAULT: begin
          if (transfer) begin
            inst_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a 16-word program model feeds imem, expected
// deliveries are queued with the stimulus and checked as decode accepts them.
`default_nettype none

module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        halted;
  logic        fetch_fault;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem[DEPTH];
  int          n_checks = 0;
  int          n_errors = 0;

  fetch_unit #(
    .RESET_PC  (32'd0),
    .IMEM_DEPTH(DEPTH),
    .WIDTH     (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_pc       (imem_pc),
    .imem_inst     (imem_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .halted        (halted),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  always_comb begin
    imem_inst = 32'd0;
    if (imem_pc < 32'(DEPTH)) imem_inst = mem[imem_pc[3:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [26:0] imm);
    return {op, imm};
  endfunction

  task automatic push_pc(input int pc);
    exp_t e;
    e.pc   = 32'(pc);
    e.data = mem[pc];
    sb_q.push_back(e);
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) push_pc(p);
  endtask

  // Decode side: every accepted word must be the next one the bench expects.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_pc", inst_pc, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_pc", inst_pc, e.pc);
        check("sb_data", inst_data, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    step();
    step();
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_imem_pc", imem_pc, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic wait_pc(input logic [31:0] pc, input int max);
    int n = 0;
    while (!(inst_valid && inst_pc == pc) && n < max) begin
      step();
      n++;
    end
    check("wait_pc_valid", {31'd0, inst_valid}, 32'd1);
    check("wait_pc", inst_pc, pc);
  endtask

  task automatic wait_halted(input int max);
    int n = 0;
    while (!halted && n < max) begin
      step();
      n++;
    end
    check("halted", {31'd0, halted}, 32'd1);
    check("halted_valid", {31'd0, inst_valid}, 32'd0);
    check("halted_imem_pc", imem_pc, 32'd6);
  endtask

  task automatic check_drained(input string tag);
    check(tag, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = mk(OP_MOV, 27'(16'hA000 + i));
    mem[0] = mk(OP_MOV, 27'd11);
    mem[1] = mk(OP_MOV, 27'd22);
    mem[2] = mk(OP_MPY, 27'd33);
    mem[3] = mk(OP_ADD, 27'd44);
    mem[4] = mk(OP_CMP, 27'd55);
    mem[5] = mk(OP_BR, 27'h7FF_FFFD);
    mem[6] = mk(OP_HALT, 27'd0);

    // Straight-line stream to HALT.
    do_reset();
    push_range(0, 6);
    inst_ready = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      step();
      check("stream_valid", {31'd0, inst_valid}, 32'd1);
      check("stream_pc", inst_pc, 32'(k));
      check("stream_not_halted", {31'd0, halted}, 32'd0);
    end
    step();
    check("stream_halted", {31'd0, halted}, 32'd1);
    check("stream_imem_pc", imem_pc, 32'd6);
    step();
    check("stream_halt_hold", imem_pc, 32'd6);
    check_drained("stream_drained");

    // Backpressure at PC 2.
    do_reset();
    push_range(0, 6);
    inst_ready = 1'b1;
    step();
    step();
    step();
    check("bp_pc2", inst_pc, 32'd2);
    inst_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold_pc", inst_pc, 32'd2);
      check("bp_hold_data", inst_data, mem[2]);
      check("bp_hold_valid", {31'd0, inst_valid}, 32'd1);
      check("bp_imem_pc", imem_pc, 32'd3);
    end
    inst_ready = 1'b1;
    step();
    check("bp_release_pc", inst_pc, 32'd3);
    wait_halted(20);
    check_drained("bp_drained");

    // Redirect loop back to PC 2, six times.
    do_reset();
    push_range(0, 5);
    for (int l = 0; l < 6; l++) push_range(2, 5);
    push_pc(6);
    inst_ready = 1'b1;
    step();
    wait_pc(32'd5, 20);
    for (int l = 0; l < 6; l++) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'd2;
      step();
      redirect_valid = 1'b0;
      check("rd_flush_valid", {31'd0, inst_valid}, 32'd0);
      check("rd_imem_pc", imem_pc, 32'd2);
      step();
      check("rd_target_valid", {31'd0, inst_valid}, 32'd1);
      check("rd_target_pc", inst_pc, 32'd2);
      if (l < 5) wait_pc(32'd5, 10);
    end
    wait_halted(20);
    check_drained("rd_drained");

    // HALT held by backpressure, then squashed by an older branch.
    do_reset();
    push_range(0, 5);
    push_range(2, 6);
    inst_ready = 1'b1;
    step();
    wait_pc(32'd5, 20);
    step();
    check("sq_halt_pc", inst_pc, 32'd6);
    inst_ready = 1'b0;
    step();
    step();
    check("sq_halt_held", inst_pc, 32'd6);
    check("sq_not_halted", {31'd0, halted}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd2;
    step();
    redirect_valid = 1'b0;
    check("sq_flush_valid", {31'd0, inst_valid}, 32'd0);
    check("sq_still_not_halted", {31'd0, halted}, 32'd0);
    inst_ready = 1'b1;
    step();
    check("sq_restart_pc", inst_pc, 32'd2);
    wait_halted(20);
    check_drained("sq_drained");

    // Redirect beyond memory depth.
    do_reset();
    push_pc(0);
    inst_ready = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'd20;
    step();
    redirect_valid = 1'b0;
    check("flt_flush_valid", {31'd0, inst_valid}, 32'd0);
    check("flt_not_yet", {31'd0, fetch_fault}, 32'd0);
    check("flt_imem_pc", imem_pc, 32'd20);
    step();
    check("flt_fault", {31'd0, fetch_fault}, 32'd1);
    check("flt_no_capture", {31'd0, inst_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd0;
    step();
    redirect_valid = 1'b0;
    check("flt_redirect_ignored", imem_pc, 32'd20);
    step();
    step();
    check("flt_sticky", {31'd0, fetch_fault}, 32'd1);
    check("flt_valid_low", {31'd0, inst_valid}, 32'd0);
    check_drained("flt_drained");

    // Reset while PC 4 is buffered.
    do_reset();
    push_range(0, 3);
    inst_ready = 1'b1;
    step();
    wait_pc(32'd4, 20);
    rst_n = 1'b0;
    step();
    check("mr_valid", {31'd0, inst_valid}, 32'd0);
    check("mr_imem_pc", imem_pc, 32'd0);
    check("mr_halted", {31'd0, halted}, 32'd0);
    check("mr_fault", {31'd0, fetch_fault}, 32'd0);
    rst_n = 1'b1;
    push_range(0, 6);
    step();
    check("mr_restart_pc", inst_pc, 32'd0);
    check("mr_restart_valid", {31'd0, inst_valid}, 32'd1);
    wait_halted(20);
    check_drained("mr_drained");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end and the requesting side of the instruction memory port.
- Drives a word-indexed PC into the combinational-read instruction memory and captures the returned word into a one-entry output register.
- Presents that word to decode over a valid/ready handshake.
- Accepts PC redirects from the branch unit, stops fetching on HALT, and flags fetches beyond the memory depth.

Parameters:
RESET_PC, 32'd0, fetch address loaded on reset
IMEM_DEPTH, 16, number of instruction words; valid PCs are 0..IMEM_DEPTH-1
WIDTH, `WIDTH (32), instruction word width, taken from the shared defines header

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
imem_pc  out  32  word address to instruction memory (equals fetch_pc register)
imem_inst  in  WIDTH  instruction word returned combinationally for imem_pc
redirect_valid  in  1  branch taken this cycle; single-cycle pulse
redirect_pc  in  32  branch target word address
inst_valid  out  1  output register holds an instruction for decode
inst_ready  in  1  decode accepts the instruction this cycle
inst_data  out  WIDTH  instruction word
inst_pc  out  32  PC of inst_data
halted  out  1  HALT delivered to decode; fetch stopped
fetch_fault  out  1  fetch attempted at PC >= IMEM_DEPTH

Behaviour:
- Reset (rst_n=0 at clk edge):
  - fetch_pc=RESET_PC, state=RUN.
  - inst_valid=0, inst_data=0, inst_pc=0, halted=0, fetch_fault=0.
  - Reset mid-operation discards the buffered instruction and any pending halt or fault.
- Handshake:
  - A transfer occurs when inst_valid && inst_ready.
  - inst_data and inst_pc are held stable while inst_valid && !inst_ready.
- Slot free: the output register is free when !inst_valid, or when a transfer occurs this cycle.
- States:
  - RUN: normal fetching.
  - HALT_WAIT: HALT captured, not yet taken by decode.
  - HALTED: halt complete.
  - FAULT: out-of-range fetch attempted.
- RUN, per cycle, in priority order:
  1. redirect_valid: flush (inst_valid=0 next cycle; a transfer in the same cycle still counts as delivered), fetch_pc=redirect_pc, no capture.
  2. Slot free and fetch_pc >= IMEM_DEPTH: no capture; go to FAULT, fetch_fault=1.
  3. Slot free: capture inst_data=imem_inst, inst_pc=fetch_pc, inst_valid=1, fetch_pc=fetch_pc+1 (32-bit wrap).
     - If imem_inst[31:27] == `HALT: go to HALT_WAIT and do not increment fetch_pc.
  4. Otherwise hold.
- Throughput: with inst_ready held high, one instruction per cycle. Fetch-to-valid latency is 1 cycle; redirect-to-valid at the target is 2 cycles.
- HALT_WAIT:
  - redirect_valid: flush the HALT, fetch_pc=redirect_pc, return to RUN. An older branch squashes the halt.
  - Transfer of the HALT: inst_valid=0, go to HALTED, halted=1 from the next cycle.
- HALTED: terminal until reset. inst_valid=0; redirects ignored; imem_pc holds the HALT PC.
- FAULT: terminal until reset. Any already-buffered instruction still drains normally; redirects ignored; fetch_fault stays 1.
- fetch_pc does not advance while the slot is occupied and not transferring (backpressure).

Decomposition:
- Shared defines header (already holds `WIDTH and opcodes such as `HALT and `BR); add:
  - OPCODE_MSB=31 and OPCODE_LSB=27
  - fetch state encodings: FS_RUN, FS_HALT_WAIT, FS_HALTED, FS_FAULT
- No sub-module is required. The optional helper fetch_out_reg (a one-entry valid/ready pipe register with flush) is acceptable if reused by later pipeline stages.

Test Plan:
- Stream: program MOV,MOV,MPY,ADD,CMP,BR(-3),HALT; inst_ready=1, no redirects -> inst_pc 0,1,2,3,4,5,6 on consecutive cycles; halted=1 one cycle after PC 6 transfers; imem_pc stays 6.
- Backpressure: inst_ready=0 for 3 cycles while inst_pc=2 -> inst_data/inst_pc hold the MPY word at PC 2, imem_pc stays 3; release -> PC 3 follows next cycle.
- Redirect: redirect_valid with redirect_pc=2 while inst_pc=5 is valid -> inst_valid=0 next cycle, then inst_pc=2; loop repeated 6 times -> HALT at PC 6 reached and halted=1.
- Halt squash: HALT captured at PC 6 with inst_ready=0, then redirect_pc=2 -> state returns to RUN, halted stays 0, next inst_pc=2.
- Fault: redirect_pc=20 with IMEM_DEPTH=16 -> no capture, fetch_fault=1 next cycle, inst_valid stays 0; a later redirect_pc=0 is ignored.
- Reset mid-run: rst_n=0 for 1 cycle while inst_valid=1 at PC 4 -> inst_valid=0, imem_pc=0, all flags clear; fetch restarts at PC 0.
